// File: rtl/axi_lite_chk_pkg.sv
// Shared types, constants and helpers for the AXI4-Lite protocol checker.
// Error IDs double as bit positions in the sticky error bitmap.
package axi_lite_chk_pkg;

    localparam int ERR_W = 14;

    typedef enum logic [3:0] {
        ERR_AW_DROP   = 4'd0,
        ERR_W_DROP    = 4'd1,
        ERR_B_DROP    = 4'd2,
        ERR_AR_DROP   = 4'd3,
        ERR_R_DROP    = 4'd4,
        ERR_AW_CHANGE = 4'd5,
        ERR_W_CHANGE  = 4'd6,
        ERR_B_CHANGE  = 4'd7,
        ERR_AR_CHANGE = 4'd8,
        ERR_R_CHANGE  = 4'd9,
        ERR_B_NO_REQ  = 4'd10,
        ERR_R_NO_REQ  = 4'd11,
        ERR_OVERFLOW  = 4'd12,
        ERR_TIMEOUT   = 4'd13
    } err_id_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    function automatic int cnt_width(input int max_outstanding);
        return $clog2(max_outstanding + 1);
    endfunction

    // Priority encode: the lowest set ID wins so err_code is deterministic.
    function automatic logic [3:0] lowest_err(input logic [ERR_W-1:0] bits);
        logic [3:0] id;
        id = '0;
        for (int i = ERR_W - 1; i >= 0; i--) begin
            if (bits[i]) id = 4'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/axi_lite_chk_chan.sv
// Per-channel VALID/payload stability monitor: remembers a stall and flags a
// dropped VALID or a payload that moved before the handshake completed.
module axi_lite_chk_chan
    import axi_lite_chk_pkg::*;
#(
    parameter int PAYLOAD_W = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic                 ready_i,
    input  logic [PAYLOAD_W-1:0] payload_i,
    output logic                 drop_err_o,
    output logic                 change_err_o
);

    logic                 stall_q;
    logic [PAYLOAD_W-1:0] payload_q;
    logic                 stall_now;

    assign stall_now = valid_i & ~ready_i;

    // Payload is recaptured on every stalled edge, so a single change is reported once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            stall_q <= stall_now;
            if (stall_now) begin
                payload_q <= payload_i;
            end
        end
    end

    assign drop_err_o   = stall_q & ~valid_i;
    assign change_err_o = stall_q & valid_i & (payload_i != payload_q);

endmodule

// File: rtl/axi_lite_protocol_checker.sv
// Passive AXI4-Lite link monitor: stability, outstanding-count, orphan-response
// and timeout checks, reported through registered pulse and sticky outputs.
module axi_lite_protocol_checker
    import axi_lite_chk_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [ADDR_W-1:0]                     awaddr_i,
    input  logic                                  awvalid_i,
    input  logic                                  awready_i,
    input  logic [DATA_W-1:0]                     wdata_i,
    input  logic [DATA_W/8-1:0]                   wstrb_i,
    input  logic                                  wvalid_i,
    input  logic                                  wready_i,
    input  logic [1:0]                            bresp_i,
    input  logic                                  bvalid_i,
    input  logic                                  bready_i,
    input  logic [ADDR_W-1:0]                     araddr_i,
    input  logic                                  arvalid_i,
    input  logic                                  arready_i,
    input  logic [DATA_W-1:0]                     rdata_i,
    input  logic [1:0]                            rresp_i,
    input  logic                                  rvalid_i,
    input  logic                                  rready_i,
    input  logic                                  err_clear_i,
    output logic                                  err_valid_o,
    output logic [3:0]                            err_code_o,
    output logic [ERR_W-1:0]                      err_sticky_o,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0] wr_pending_o,
    output logic [cnt_width(MAX_OUTSTANDING)-1:0] rd_pending_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = cnt_width(MAX_OUTSTANDING);
    localparam int TMR_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit               TMR_EN   = (TIMEOUT_CYCLES > 0);

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_drop, w_drop, b_drop, ar_drop, r_drop;
    logic aw_chg, w_chg, b_chg, ar_chg, r_chg;

    logic [CNT_W-1:0] aw_cnt_q, aw_cnt_d;
    logic [CNT_W-1:0] w_cnt_q, w_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0] wr_pending;

    logic [TMR_W-1:0] wr_tmr_q, wr_tmr_d;
    logic [TMR_W-1:0] rd_tmr_q, rd_tmr_d;
    logic             wr_tmr_run, rd_tmr_run;
    logic             wr_timeout, rd_timeout;

    logic             b_no_req, r_no_req, overflow;
    logic [ERR_W-1:0] err_bits;

    logic             err_valid_q;
    logic [3:0]       err_code_q;
    logic [ERR_W-1:0] err_sticky_q;

    assign aw_hs = awvalid_i & awready_i;
    assign w_hs  = wvalid_i  & wready_i;
    assign b_hs  = bvalid_i  & bready_i;
    assign ar_hs = arvalid_i & arready_i;
    assign r_hs  = rvalid_i  & rready_i;

    axi_lite_chk_chan #(.PAYLOAD_W(ADDR_W)) u_aw_chan (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(awvalid_i), .ready_i(awready_i),
        .payload_i(awaddr_i), .drop_err_o(aw_drop), .change_err_o(aw_chg)
    );

    axi_lite_chk_chan #(.PAYLOAD_W(DATA_W + STRB_W)) u_w_chan (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(wvalid_i), .ready_i(wready_i),
        .payload_i({wdata_i, wstrb_i}), .drop_err_o(w_drop), .change_err_o(w_chg)
    );

    axi_lite_chk_chan #(.PAYLOAD_W(2)) u_b_chan (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(bvalid_i), .ready_i(bready_i),
        .payload_i(bresp_i), .drop_err_o(b_drop), .change_err_o(b_chg)
    );

    axi_lite_chk_chan #(.PAYLOAD_W(ADDR_W)) u_ar_chan (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(arvalid_i), .ready_i(arready_i),
        .payload_i(araddr_i), .drop_err_o(ar_drop), .change_err_o(ar_chg)
    );

    axi_lite_chk_chan #(.PAYLOAD_W(DATA_W + 2)) u_r_chan (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(rvalid_i), .ready_i(rready_i),
        .payload_i({rdata_i, rresp_i}), .drop_err_o(r_drop), .change_err_o(r_chg)
    );

    // Saturating up/down step; a simultaneous inc and dec cancel out.
    function automatic logic [CNT_W-1:0] step_cnt(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic dec);
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && cnt != CNT_MAX) nxt = cnt + 1'b1;
        if (dec && !inc && cnt != '0)      nxt = cnt - 1'b1;
        return nxt;
    endfunction

    assign wr_pending = (aw_cnt_q < w_cnt_q) ? aw_cnt_q : w_cnt_q;

    always_comb begin
        aw_cnt_d = step_cnt(aw_cnt_q, aw_hs, b_hs);
        w_cnt_d  = step_cnt(w_cnt_q,  w_hs,  b_hs);
        rd_cnt_d = step_cnt(rd_cnt_q, ar_hs, r_hs);
    end

    // Timers stop at TMR_MAX so the timeout fires exactly once per stuck wait.
    always_comb begin
        wr_tmr_run = (wr_pending != '0) && !b_hs;
        rd_tmr_run = (rd_cnt_q != '0) && !r_hs;

        wr_tmr_d = '0;
        if (wr_tmr_run) wr_tmr_d = (wr_tmr_q == TMR_MAX) ? wr_tmr_q : wr_tmr_q + 1'b1;
        rd_tmr_d = '0;
        if (rd_tmr_run) rd_tmr_d = (rd_tmr_q == TMR_MAX) ? rd_tmr_q : rd_tmr_q + 1'b1;

        wr_timeout = TMR_EN && wr_tmr_run && (wr_tmr_q == TMR_LAST);
        rd_timeout = TMR_EN && rd_tmr_run && (rd_tmr_q == TMR_LAST);
    end

    // Orphan-response checks look at registered counts, so a response in the
    // same cycle as its request handshake is still flagged.
    always_comb begin
        b_no_req = bvalid_i && (aw_cnt_q == '0 || w_cnt_q == '0);
        r_no_req = rvalid_i && (rd_cnt_q == '0);
        overflow = (aw_hs && !b_hs && aw_cnt_q == CNT_MAX) ||
                   (w_hs  && !b_hs && w_cnt_q  == CNT_MAX) ||
                   (ar_hs && !r_hs && rd_cnt_q == CNT_MAX);

        err_bits                = '0;
        err_bits[ERR_AW_DROP]   = aw_drop;
        err_bits[ERR_W_DROP]    = w_drop;
        err_bits[ERR_B_DROP]    = b_drop;
        err_bits[ERR_AR_DROP]   = ar_drop;
        err_bits[ERR_R_DROP]    = r_drop;
        err_bits[ERR_AW_CHANGE] = aw_chg;
        err_bits[ERR_W_CHANGE]  = w_chg;
        err_bits[ERR_B_CHANGE]  = b_chg;
        err_bits[ERR_AR_CHANGE] = ar_chg;
        err_bits[ERR_R_CHANGE]  = r_chg;
        err_bits[ERR_B_NO_REQ]  = b_no_req;
        err_bits[ERR_R_NO_REQ]  = r_no_req;
        err_bits[ERR_OVERFLOW]  = overflow;
        err_bits[ERR_TIMEOUT]   = wr_timeout | rd_timeout;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            aw_cnt_q     <= '0;
            w_cnt_q      <= '0;
            rd_cnt_q     <= '0;
            wr_tmr_q     <= '0;
            rd_tmr_q     <= '0;
            err_valid_q  <= 1'b0;
            err_code_q   <= '0;
            err_sticky_q <= '0;
        end else begin
            aw_cnt_q     <= aw_cnt_d;
            w_cnt_q      <= w_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            wr_tmr_q     <= wr_tmr_d;
            rd_tmr_q     <= rd_tmr_d;
            err_valid_q  <= |err_bits;
            err_code_q   <= lowest_err(err_bits);
            err_sticky_q <= err_clear_i ? err_bits : (err_sticky_q | err_bits);
        end
    end

    assign err_valid_o  = err_valid_q;
    assign err_code_o   = err_code_q;
    assign err_sticky_o = err_sticky_q;
    assign wr_pending_o = wr_pending;
    assign rd_pending_o = rd_cnt_q;

endmodule

// File: tb/tb_axi_lite_protocol_checker.sv
// Directed bench for the AXI4-Lite protocol checker (MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
module tb_axi_lite_protocol_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, err_clear;
    logic        err_valid;
    logic [3:0]  err_code;
    logic [13:0] err_sticky;
    logic [2:0]  wr_pending, rd_pending;

    int check_cnt = 0;
    int pass_cnt  = 0;

    axi_lite_protocol_checker #(
        .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_i(awready),
        .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_i(wready),
        .bresp_i(bresp), .bvalid_i(bvalid), .bready_i(bready),
        .araddr_i(araddr), .arvalid_i(arvalid), .arready_i(arready),
        .rdata_i(rdata), .rresp_i(rresp), .rvalid_i(rvalid), .rready_i(rready),
        .err_clear_i(err_clear),
        .err_valid_o(err_valid), .err_code_o(err_code), .err_sticky_o(err_sticky),
        .wr_pending_o(wr_pending), .rd_pending_o(rd_pending)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
        arvalid = 0; arready = 0; rvalid = 0; rready = 0; err_clear = 0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; rdata = '0;
        bresp = 2'b00; rresp = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        check_cnt++;
        if (err_valid !== 1'b0) $display("[TB] FAIL reset_err_valid: got %0b want 0", err_valid); else pass_cnt++;
        check_cnt++;
        if (err_code !== 4'd0) $display("[TB] FAIL reset_err_code: got %0d want 0", err_code); else pass_cnt++;
        check_cnt++;
        if (err_sticky !== 14'h0) $display("[TB] FAIL reset_sticky: got %h want 0000", err_sticky); else pass_cnt++;
        check_cnt++;
        if (wr_pending !== 3'd0) $display("[TB] FAIL reset_wr_pending: got %0d want 0", wr_pending); else pass_cnt++;
        check_cnt++;
        if (rd_pending !== 3'd0) $display("[TB] FAIL reset_rd_pending: got %0d want 0", rd_pending); else pass_cnt++;
        rst = 0;
    endtask

    task automatic test_compliant();
        do_reset();
        awaddr = 32'h10; awvalid = 1; awready = 1;
        wdata = 32'hCAFE_0001; wstrb = 4'hF; wvalid = 1; wready = 1;
        tick();
        check_cnt++;
        if (wr_pending !== 3'd1) $display("[TB] FAIL ok_wr_pending_1: got %0d want 1", wr_pending); else pass_cnt++;
        idle();
        tick();
        bvalid = 1; bready = 1; bresp = 2'b00;
        tick();
        check_cnt++;
        if (wr_pending !== 3'd0) $display("[TB] FAIL ok_wr_pending_0: got %0d want 0", wr_pending); else pass_cnt++;
        idle();
        araddr = 32'h20; arvalid = 1; arready = 1;
        tick();
        check_cnt++;
        if (rd_pending !== 3'd1) $display("[TB] FAIL ok_rd_pending_1: got %0d want 1", rd_pending); else pass_cnt++;
        idle();
        tick();
        rdata = 32'h1234_5678; rvalid = 1; rready = 1;
        tick();
        check_cnt++;
        if (rd_pending !== 3'd0) $display("[TB] FAIL ok_rd_pending_0: got %0d want 0", rd_pending); else pass_cnt++;
        idle();
        tick();
        check_cnt++;
        if (err_sticky !== 14'h0) $display("[TB] FAIL ok_sticky: got %h want 0000", err_sticky); else pass_cnt++;
    endtask

    task automatic test_valid_drop();
        do_reset();
        awaddr = 32'h200; awvalid = 1; awready = 0;
        tick();
        tick();
        check_cnt++;
        if (err_valid !== 1'b0) $display("[TB] FAIL drop_stall_quiet: got %0b want 0", err_valid); else pass_cnt++;
        awvalid = 0;
        tick();
        check_cnt++;
        if (err_valid !== 1'b1) $display("[TB] FAIL drop_err_valid: got %0b want 1", err_valid); else pass_cnt++;
        check_cnt++;
        if (err_code !== 4'd0) $display("[TB] FAIL drop_err_code: got %0d want 0", err_code); else pass_cnt++;
        check_cnt++;
        if (err_sticky !== 14'h0001) $display("[TB] FAIL drop_sticky: got %h want 0001", err_sticky); else pass_cnt++;
        idle();
        tick();
        check_cnt++;
        if (err_valid !== 1'b0) $display("[TB] FAIL drop_pulse_width: got %0b want 0", err_valid); else pass_cnt++;
        check_cnt++;
        if (err_sticky !== 14'h0001) $display("[TB] FAIL drop_sticky_hold: got %h want 0001", err_sticky); else pass_cnt++;
        err_clear = 1;
        tick();
        err_clear = 0;
        check_cnt++;
        if (err_sticky !== 14'h0) $display("[TB] FAIL drop_clear: got %h want 0000", err_sticky); else pass_cnt++;
    endtask

    task automatic test_payload_change();
        do_reset();
        araddr = 32'h100; arvalid = 1; arready = 0;
        wdata = 32'hA5; wstrb = 4'hF; wvalid = 1; wready = 0;
        tick();
        araddr = 32'h104; wdata = 32'h5A;
        tick();
        check_cnt++;
        if (err_valid !== 1'b1) $display("[TB] FAIL chg_err_valid: got %0b want 1", err_valid); else pass_cnt++;
        check_cnt++;
        if (err_code !== 4'd6) $display("[TB] FAIL chg_err_code: got %0d want 6", err_code); else pass_cnt++;
        check_cnt++;
        if (err_sticky !== 14'h0140) $display("[TB] FAIL chg_sticky: got %h want 0140", err_sticky); else pass_cnt++;
        arready = 1; wready = 1; err_clear = 1;
        tick();
        idle();
        check_cnt++;
        if (err_sticky !== 14'h0) $display("[TB] FAIL chg_clear: got %h want 0000", err_sticky); else pass_cnt++;
        check_cnt++;
        if (err_valid !== 1'b0) $display("[TB] FAIL chg_stable_hs: got %0b want 0", err_valid); else pass_cnt++;
        check_cnt++;
        if (rd_pending !== 3'd1) $display("[TB] FAIL chg_rd_pending: got %0d want 1", rd_pending); else pass_cnt++;
    endtask

    task automatic test_no_req();
        do_reset();
        bvalid = 1; bready = 1; bresp = 2'b10;
        tick();
        check_cnt++;
        if (err_code !== 4'd10 || err_valid !== 1'b1)
            $display("[TB] FAIL b_no_req: got valid=%0b code=%0d want valid=1 code=10", err_valid, err_code);
        else pass_cnt++;
        check_cnt++;
        if (wr_pending !== 3'd0) $display("[TB] FAIL b_no_req_pending: got %0d want 0", wr_pending); else pass_cnt++;
        idle();
        tick();
        araddr = 32'h40; arvalid = 1; arready = 1;
        rdata = 32'h77; rvalid = 1; rready = 1;
        tick();
        idle();
        check_cnt++;
        if (err_code !== 4'd11 || err_valid !== 1'b1)
            $display("[TB] FAIL r_no_req: got valid=%0b code=%0d want valid=1 code=11", err_valid, err_code);
        else pass_cnt++;
        check_cnt++;
        if (err_sticky !== 14'h0C00) $display("[TB] FAIL no_req_sticky: got %h want 0c00", err_sticky); else pass_cnt++;
        check_cnt++;
        if (rd_pending !== 3'd0) $display("[TB] FAIL r_no_req_pending: got %0d want 0", rd_pending); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [2:0] exp_pend;
        logic       exp_valid;
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            araddr = 32'h1000 + 32'(i * 4); arvalid = 1; arready = 1;
            tick();
            exp_pend  = (i > 4) ? 3'd4 : 3'(i);
            exp_valid = (i == 5);
            check_cnt++;
            if (rd_pending !== exp_pend || err_valid !== exp_valid)
                $display("[TB] FAIL ovf_ar_%0d: got pend=%0d valid=%0b want pend=%0d valid=%0b",
                         i, rd_pending, err_valid, exp_pend, exp_valid);
            else pass_cnt++;
        end
        check_cnt++;
        if (err_code !== 4'd12) $display("[TB] FAIL ovf_code: got %0d want 12", err_code); else pass_cnt++;
        idle();
        for (int i = 1; i <= 4; i++) begin
            rdata = 32'(i); rvalid = 1; rready = 1;
            tick();
            exp_pend = 3'(4 - i);
            check_cnt++;
            if (rd_pending !== exp_pend || err_valid !== 1'b0)
                $display("[TB] FAIL ovf_r_%0d: got pend=%0d valid=%0b want pend=%0d valid=0",
                         i, rd_pending, err_valid, exp_pend);
            else pass_cnt++;
        end
        idle();
        tick();
        check_cnt++;
        if (err_sticky !== 14'h1000) $display("[TB] FAIL ovf_sticky: got %h want 1000", err_sticky); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        awaddr = 32'h300; awvalid = 1; awready = 1;
        wdata = 32'h99; wstrb = 4'h3; wvalid = 1; wready = 1;
        tick();
        idle();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check_cnt++;
            if (err_valid !== 1'b0) $display("[TB] FAIL tmo_early_%0d: got %0b want 0", i, err_valid); else pass_cnt++;
        end
        tick();
        check_cnt++;
        if (err_valid !== 1'b1 || err_code !== 4'd13)
            $display("[TB] FAIL tmo_fire: got valid=%0b code=%0d want valid=1 code=13", err_valid, err_code);
        else pass_cnt++;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_cnt++;
            if (err_valid !== 1'b0) $display("[TB] FAIL tmo_single_%0d: got %0b want 0", i, err_valid); else pass_cnt++;
        end
        check_cnt++;
        if (err_sticky !== 14'h2000 || wr_pending !== 3'd1)
            $display("[TB] FAIL tmo_state: got sticky=%h pend=%0d want sticky=2000 pend=1", err_sticky, wr_pending);
        else pass_cnt++;
        rst = 1;
        tick();
        rst = 0;
        check_cnt++;
        if (err_valid !== 1'b0 || err_code !== 4'd0 || err_sticky !== 14'h0 ||
            wr_pending !== 3'd0 || rd_pending !== 3'd0)
            $display("[TB] FAIL tmo_reset: got valid=%0b code=%0d sticky=%h wr=%0d rd=%0d want all 0",
                     err_valid, err_code, err_sticky, wr_pending, rd_pending);
        else pass_cnt++;
        for (int i = 1; i <= 20; i++) tick();
        check_cnt++;
        if (err_sticky !== 14'h0) $display("[TB] FAIL tmo_after_reset: got %h want 0000", err_sticky); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000 want finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_compliant();
        test_valid_drop();
        test_payload_change();
        test_no_req();
        test_overflow();
        test_timeout();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
